// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce bank.
//   state_e : per-channel debounce FSM encoding; bit [1] is the debounced level.
//   clog2   : ceil(log2(value)), used to size the stability counter.
package debounce_pkg;

  typedef enum logic [1:0] {
    WAIT_HIGH   = 2'b00,
    CHECK_HIGH  = 2'b01,
    STABLE_HIGH = 2'b10,
    CHECK_LOW   = 2'b11
  } state_e;

  // Inputs here are small elaboration constants, so a short fixed loop covers them.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 16; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: input synchroniser, 4-state stability FSM with run
// counter, and registered rise/fall flags.
//   clk, rst      : clock, asynchronous active-high reset
//   en            : sample-enable tick; FSM, counter and level advance only when 1
//   pulse_in      : raw asynchronous input
//   level_out     : debounced level (registered)
//   rise, fall    : one-clk pulses on debounced 0->1 / 1->0
//   edge_next     : next-cycle value of (rise | fall), lets the parent register
//                   a combined flag aligned with rise/fall
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic pulse_in,
  output logic level_out,
  output logic rise,
  output logic fall,
  output logic edge_next
);

  localparam int              CW       = clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          cnt_inc;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  // The synchroniser runs every clock, independent of en.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], pulse_in};
  assign s      = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CW'(1);
    if (en) begin
      case (state_q)
        WAIT_HIGH: begin
          if (s) begin
            if (STABLE_CYCLES == 1) begin
              state_d = STABLE_HIGH;
              cnt_d   = '0;
            end else begin
              state_d = CHECK_HIGH;
              cnt_d   = CW'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        CHECK_HIGH: begin
          if (!s) begin
            state_d = WAIT_HIGH;     // glitch rejected
            cnt_d   = '0;
          end else if (cnt_inc == CNT_LAST) begin
            state_d = STABLE_HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        STABLE_HIGH: begin
          if (!s) begin
            if (STABLE_CYCLES == 1) begin
              state_d = WAIT_HIGH;
              cnt_d   = '0;
            end else begin
              state_d = CHECK_LOW;
              cnt_d   = CW'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        CHECK_LOW: begin
          if (s) begin
            state_d = STABLE_HIGH;   // glitch rejected
            cnt_d   = '0;
          end else if (cnt_inc == CNT_LAST) begin
            state_d = WAIT_HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      endcase
    end
    // state bit [1] is the level, so edges are just changes of that bit.
    rise_d = ~state_q[1] &  state_d[1];
    fall_d =  state_q[1] & ~state_d[1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= WAIT_HIGH;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_out = state_q[1];
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign edge_next = rise_d | fall_d;

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounce channels with a combined change flag.
//   clk, rst  : clock, asynchronous active-high reset
//   en        : sample-enable tick shared by all channels
//   pulse_in  : raw asynchronous inputs, one bit per channel
//   level_out : debounced levels
//   rise/fall : per-channel one-clk edge pulses
//   changed   : OR of all rise/fall bits, valid in the same cycle as them
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] pulse_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed
);

  logic [CHANNELS-1:0] edge_next;
  logic                changed_q, changed_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .pulse_in  (pulse_in[i]),
      .level_out (level_out[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .edge_next (edge_next[i])
    );
  end

  // Built from the channels' next-cycle edge bits so it lands with rise/fall.
  always_comb begin
    changed_d = |edge_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) changed_q <= 1'b0;
    else     changed_q <= changed_d;
  end

  assign changed = changed_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench: two instances (STABLE_CYCLES=4 and =1) share stimulus.
// A reference model tracks, per channel, the synchronised sample stream and the
// length of the current run of enabled samples disagreeing with the level.
// Predicted edge events go into per-DUT queues; a monitor pops them whenever
// the DUT raises changed (or an event is due) and compares.
module tb_debounce_bank;

  localparam int CH   = 4;
  localparam int SYNC = 2;

  typedef struct {
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [CH-1:0] pulse_in = '0;

  logic [CH-1:0] lvl_a, rise_a, fall_a, lvl_b, rise_b, fall_b;
  logic          chg_a, chg_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  debounce_bank #(.CHANNELS(CH), .STABLE_CYCLES(4), .SYNC_STAGES(SYNC)) dut_a (
    .clk(clk), .rst(rst), .en(en), .pulse_in(pulse_in),
    .level_out(lvl_a), .rise(rise_a), .fall(fall_a), .changed(chg_a));

  debounce_bank #(.CHANNELS(CH), .STABLE_CYCLES(1), .SYNC_STAGES(SYNC)) dut_b (
    .clk(clk), .rst(rst), .en(en), .pulse_in(pulse_in),
    .level_out(lvl_b), .rise(rise_b), .fall(fall_b), .changed(chg_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int      stable_n [2] = '{4, 1};
  bit      sh  [2][CH][SYNC];
  bit      lvl [2][CH];
  int      run [2][CH];
  ev_t     qa[$];
  ev_t     qb[$];

  function automatic logic [CH-1:0] model_level(input int d);
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = lvl[d][c];
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < SYNC; k++) sh[d][c][k] = 1'b0;
        lvl[d][c] = 1'b0;
        run[d][c] = 0;
      end
    qa.delete();
    qb.delete();
  endtask

  task automatic model_edge(input bit e, input logic [CH-1:0] p);
    for (int d = 0; d < 2; d++) begin
      ev_t ev;
      ev.rise = '0;
      ev.fall = '0;
      for (int c = 0; c < CH; c++) begin
        bit s_old;
        s_old = sh[d][c][SYNC-1];
        for (int k = SYNC - 1; k > 0; k--) sh[d][c][k] = sh[d][c][k-1];
        sh[d][c][0] = p[c];
        if (e) begin
          if (s_old != lvl[d][c]) begin
            run[d][c]++;
            if (run[d][c] == stable_n[d]) begin
              lvl[d][c] = s_old;
              run[d][c] = 0;
              if (s_old) ev.rise[c] = 1'b1;
              else       ev.fall[c] = 1'b1;
            end
          end else begin
            run[d][c] = 0;
          end
        end
      end
      if ((ev.rise | ev.fall) != '0) begin
        if (d == 0) qa.push_back(ev);
        else        qb.push_back(ev);
      end
    end
  endtask

  // ---------------- monitor ----------------
  task automatic monitor_dut(input int d, input logic [CH-1:0] l, input logic [CH-1:0] r,
                             input logic [CH-1:0] f, input logic chg);
    ev_t ev;
    bit  have;
    string tag;
    tag  = (d == 0) ? "a" : "b";
    have = (d == 0) ? (qa.size() != 0) : (qb.size() != 0);
    check({"level_", tag}, 32'(l), 32'(model_level(d)));
    if (chg || have) begin
      if (!have) begin
        check({"unexpected_changed_", tag}, 32'(chg), 32'(0));
      end else begin
        ev = (d == 0) ? qa.pop_front() : qb.pop_front();
        check({"changed_", tag}, 32'(chg), 32'(1));
        check({"rise_", tag}, 32'(r), 32'(ev.rise));
        check({"fall_", tag}, 32'(f), 32'(ev.fall));
      end
    end else begin
      check({"quiet_edges_", tag}, 32'(r | f), 32'(0));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      monitor_dut(0, lvl_a, rise_a, fall_a, chg_a);
      monitor_dut(1, lvl_b, rise_b, fall_b, chg_b);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [CH-1:0] seen_rise_a, seen_fall_a;
  int            fall2_count;
  bit            seen_chg_a;

  task automatic cycle(input bit e, input logic [CH-1:0] p);
    en       = e;
    pulse_in = p;
    @(posedge clk);
    model_edge(e, p);
    @(negedge clk);
    seen_rise_a = seen_rise_a | rise_a;
    seen_fall_a = seen_fall_a | fall_a;
    seen_chg_a  = seen_chg_a | chg_a;
    if (fall_a[2]) fall2_count++;
  endtask

  task automatic clear_sticky();
    seen_rise_a = '0;
    seen_fall_a = '0;
    seen_chg_a  = 1'b0;
    fall2_count = 0;
  endtask

  task automatic apply_reset(input string name);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check({name, "_level_a"}, 32'(lvl_a), 32'(0));
    check({name, "_edges_a"}, 32'({rise_a, fall_a, chg_a}), 32'(0));
    check({name, "_level_b"}, 32'(lvl_b), 32'(0));
    check({name, "_edges_b"}, 32'({rise_b, fall_b, chg_b}), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    clear_sticky();
    model_reset();
    pulse_in = '0;
    en       = 1'b0;
    apply_reset("reset");
    repeat (3) cycle(1'b1, 4'b0000);

    // Channel 0 step: level and rise after edge 6, rise gone on edge 7.
    for (int i = 1; i <= 7; i++) begin
      cycle(1'b1, 4'b0001);
      if (i == 5) check("ch0_level_edge5", 32'(lvl_a[0]), 32'(0));
      if (i == 6) begin
        check("ch0_level_edge6", 32'(lvl_a[0]), 32'(1));
        check("ch0_rise_edge6", 32'(rise_a[0]), 32'(1));
      end
      if (i == 7) check("ch0_rise_edge7", 32'(rise_a[0]), 32'(0));
    end

    // Channel 1 short pulse is rejected.
    clear_sticky();
    repeat (3) cycle(1'b1, 4'b0011);
    repeat (10) cycle(1'b1, 4'b0001);
    check("ch1_no_rise", 32'(seen_rise_a[1]), 32'(0));
    check("ch1_no_changed", 32'(seen_chg_a), 32'(0));

    // Channel 2: stable high, 2-clk low glitch rejected, 4-clk low accepted.
    repeat (8) cycle(1'b1, 4'b0101);
    check("ch2_high", 32'(lvl_a[2]), 32'(1));
    clear_sticky();
    repeat (2) cycle(1'b1, 4'b0001);
    repeat (8) cycle(1'b1, 4'b0101);
    check("ch2_glitch_level", 32'(lvl_a[2]), 32'(1));
    check("ch2_glitch_no_fall", 32'(seen_fall_a[2]), 32'(0));
    repeat (4) cycle(1'b1, 4'b0001);
    repeat (6) cycle(1'b1, 4'b0001);
    check("ch2_fall_once", 32'(fall2_count), 32'(1));
    check("ch2_low", 32'(lvl_a[2]), 32'(0));

    // Channel 3 with en ticking every 4th clock.
    for (int i = 0; i < 40; i++) cycle((i % 4) == 3, 4'b1001);
    check("ch3_slow_en_level", 32'(lvl_a[3]), 32'(1));

    // Reset mid-check: clean start, ch0 high for 4 edges (cnt=2), then reset.
    apply_reset("pre_mid");
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'b0001);
    apply_reset("mid_check");
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b1, 4'b0001);
      if (i == 5) check("post_rst_edge5", 32'(lvl_a[0]), 32'(0));
      if (i == 6) check("post_rst_edge6", 32'(lvl_a[0]), 32'(1));
    end

    // All channels together on the STABLE_CYCLES=1 instance.
    apply_reset("pre_all");
    repeat (2) cycle(1'b1, 4'b0000);
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 4'b1111);
      if (i == 3) begin
        check("all_rise_b", 32'(rise_b), 32'hF);
        check("all_changed_b", 32'(chg_b), 32'(1));
      end
      if (i == 4) check("all_changed_b_next", 32'(chg_b), 32'(0));
    end

    // Randomised: slowly toggling inputs with a mostly-on enable.
    begin
      logic [CH-1:0] p;
      p = '0;
      for (int i = 0; i < 600; i++) begin
        for (int c = 0; c < CH; c++)
          if ($urandom_range(5) == 0) p[c] = ~p[c];
        cycle($urandom_range(3) != 0, p);
      end
    end
    repeat (8) cycle(1'b1, pulse_in);
    check("queue_a_drained", 32'(qa.size()), 32'(0));
    check("queue_b_drained", 32'(qb.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels, range 1..32.
REQ-002 Parameter STABLE_CYCLES, default 4: consecutive enabled samples needed to accept a level change, range 1..255.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser flops per channel, range 2..4.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  1  sample-enable tick; FSMs advance only on edges where en=1.
REQ-007 pulse_in  input  CHANNELS  raw asynchronous inputs, one bit per channel.
REQ-008 level_out  output  CHANNELS  debounced level per channel, registered.
REQ-009 rise  output  CHANNELS  one-clk pulse when level_out goes 0->1.
REQ-010 fall  output  CHANNELS  one-clk pulse when level_out goes 1->0.
REQ-011 changed  output  1  OR of all rise and fall bits, registered in the same cycle as those bits.

Function
REQ-012 Each channel SHALL pass pulse_in[i] through SYNC_STAGES flops, clocked every clk regardless of en; the last stage is s[i].
REQ-013 Each channel SHALL run a 4-state FSM: WAIT_HIGH, CHECK_HIGH, STABLE_HIGH, CHECK_LOW, plus a counter of width ceil(log2(STABLE_CYCLES+1)).
REQ-014 When en=0, FSM state, counter, and level_out SHALL hold; rise and fall SHALL be 0.
REQ-015 WAIT_HIGH, en=1, s=1: go to CHECK_HIGH with cnt=1. If STABLE_CYCLES=1, go directly to STABLE_HIGH instead. If s=0, stay with cnt=0.
REQ-016 CHECK_HIGH, en=1, s=1: cnt+1. When cnt+1 equals STABLE_CYCLES, go to STABLE_HIGH with cnt=0. If s=0, return to WAIT_HIGH with cnt=0 (glitch rejected).
REQ-017 STABLE_HIGH and CHECK_LOW SHALL mirror REQ-015/016 with s inverted. CHECK_LOW with s=1 returns to STABLE_HIGH with cnt=0.
REQ-018 level_out[i] SHALL be 1 exactly in STABLE_HIGH and CHECK_LOW; a rejected glitch SHALL NOT toggle it.
REQ-019 rise[i]/fall[i] SHALL assert for exactly one clk on the edge that enters STABLE_HIGH/WAIT_HIGH from a check state; never both in one cycle.
REQ-020 Latency with en held 1: a clean input step taken before edge 1 SHALL appear on level_out after edge SYNC_STAGES+STABLE_CYCLES (6 at defaults).
REQ-021 The counter SHALL never exceed STABLE_CYCLES and SHALL never wrap.
REQ-022 Channels SHALL be fully independent; simultaneous edges on multiple channels SHALL each produce their own rise/fall bit, with changed=1 for one cycle.

Reset
REQ-023 rst=1 SHALL immediately force all synchroniser flops to 0, all FSMs to WAIT_HIGH, and all counters, level_out, rise, fall, and changed to 0.
REQ-024 Reset asserted mid-check SHALL discard partial counts. After release, a high input SHALL need the full REQ-020 latency.
REQ-025 The first clk edge after rst deasserts SHALL behave as a normal edge.

Structure
REQ-026 Shared package debounce_pkg SHALL hold the state encoding (WAIT_HIGH=00, CHECK_HIGH=01, STABLE_HIGH=10, CHECK_LOW=11, so state[1] equals level) and a clog2 width function.
REQ-027 Per-channel logic SHALL be sub-module debounce_channel (synchroniser, FSM, counter, edge flags), instantiated CHANNELS times by generate. The top SHALL only add the changed OR-reduction register.

Verification
REQ-028 Defaults, en=1, ch0 stepped 0->1 and held -> level_out[0]=1 and rise[0]=1 after edge 6; rise[0]=0 on edge 7.
REQ-029 Defaults, ch1 high for 3 clk then low -> level_out[1] stays 0; rise[1] and changed never assert.
REQ-030 Defaults, ch2 stable high, then a 2-clk low glitch -> level_out[2] stays 1, fall[2] never asserts; a 4-clk low -> fall[2]=1 once.
REQ-031 en pulsed every 4th clk, ch3 stepped high -> level_out[3] rises on the 4th enabled edge after s=1; it holds between ticks.
REQ-032 rst asserted mid-CHECK_HIGH (cnt=2), input held high -> outputs 0 immediately; level rises 6 edges after release.
REQ-033 STABLE_CYCLES=1, all channels stepped high together -> all rise bits set after edge 3 and changed=1 for exactly one cycle.
